// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: default widths, special register indices
// and the word/address typedefs used by the register file and its read ports.
// No ports; imported with `import cpu_pkg::*`.
package cpu_pkg;

    localparam int DATA_W       = 32;
    localparam int ADDR_W       = 5;

    localparam int REG_ZERO     = 0;    // hard-wired zero register
    localparam int REG_SP       = 29;   // stack pointer
    localparam int SP_RESET_VAL = 128;  // stack pointer value out of reset

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/reg_file_if.sv
// Register file bus: two read addresses/data plus one write port.
// Modports: master (decode / write-back side drives addresses and write data),
// slave (register file drives the two read data outputs).
interface reg_file_if #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W
);
    logic [ADDR_W-1:0] rs_addr_i;
    logic [ADDR_W-1:0] rt_addr_i;
    logic [ADDR_W-1:0] rd_addr_i;
    logic [DATA_W-1:0] rd_data_i;
    logic              reg_write_i;
    logic [DATA_W-1:0] rs_data_o;
    logic [DATA_W-1:0] rt_data_o;

    modport master (
        output rs_addr_i, rt_addr_i, rd_addr_i, rd_data_i, reg_write_i,
        input  rs_data_o, rt_data_o
    );

    modport slave (
        input  rs_addr_i, rt_addr_i, rd_addr_i, rd_data_i, reg_write_i,
        output rs_data_o, rt_data_o
    );
endinterface

// File: rtl/reg_file_rd_port.sv
// One combinational read port of the register file: array select, zero-register
// mask and (when REG_FILE_BYPASS_EN is defined) write-first bypass of the
// in-flight write. Ports: regs_i (all registers), addr_i, data_o, plus the
// write-port signals rst_i/wr_en_i/wr_addr_i/wr_data_i in the bypass build.
module reg_file_rd_port
    import cpu_pkg::*;
#(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W
) (
    input  logic [2**ADDR_W-1:0][DATA_W-1:0] regs_i,
    input  logic [ADDR_W-1:0]                addr_i,
`ifdef REG_FILE_BYPASS_EN
    input  logic                             rst_i,
    input  logic                             wr_en_i,
    input  logic [ADDR_W-1:0]                wr_addr_i,
    input  logic [DATA_W-1:0]                wr_data_i,
`endif
    output logic [DATA_W-1:0]                data_o
);

    always_comb begin
        data_o = regs_i[addr_i];
`ifdef REG_FILE_BYPASS_EN
        // Forward the value that the coming edge will commit.
        if (!rst_i && wr_en_i && (wr_addr_i == addr_i)) begin
            data_o = wr_data_i;
        end
`endif
        // Applied last so neither stored state nor bypass can leak through r0.
        if (addr_i == ADDR_W'(REG_ZERO)) begin
            data_o = '0;
        end
    end

endmodule

// File: rtl/reg_file.sv
// Architectural register file: 2**ADDR_W x DATA_W, two async read ports, one
// synchronous write port; r0 reads zero, r[SP_IDX] resets to SP_RESET.
// Ports: clk_i, rst_i (sync, active-high), bus (reg_file_if.slave).
// Optional macro REG_FILE_BYPASS_EN selects write-first reads; default is
// read-before-write.
module reg_file
    import cpu_pkg::*;
#(
    parameter int DATA_W   = cpu_pkg::DATA_W,
    parameter int ADDR_W   = cpu_pkg::ADDR_W,
    parameter int SP_IDX   = REG_SP,
    parameter int SP_RESET = SP_RESET_VAL
) (
    input  logic      clk_i,
    input  logic      rst_i,
    reg_file_if.slave bus
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0][DATA_W-1:0] regs_q;
    logic [DEPTH-1:0][DATA_W-1:0] regs_d;

    always_comb begin
        regs_d = regs_q;
        if (bus.reg_write_i && (bus.rd_addr_i != '0)) begin
            regs_d[bus.rd_addr_i] = bus.rd_data_i;
        end
    end

    // Reset has priority over a write presented on the same edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= (i == SP_IDX) ? DATA_W'(SP_RESET) : '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    reg_file_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rs_port (
        .regs_i    (regs_q),
        .addr_i    (bus.rs_addr_i),
`ifdef REG_FILE_BYPASS_EN
        .rst_i     (rst_i),
        .wr_en_i   (bus.reg_write_i),
        .wr_addr_i (bus.rd_addr_i),
        .wr_data_i (bus.rd_data_i),
`endif
        .data_o    (bus.rs_data_o)
    );

    reg_file_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rt_port (
        .regs_i    (regs_q),
        .addr_i    (bus.rt_addr_i),
`ifdef REG_FILE_BYPASS_EN
        .rst_i     (rst_i),
        .wr_en_i   (bus.reg_write_i),
        .wr_addr_i (bus.rd_addr_i),
        .wr_data_i (bus.rd_data_i),
`endif
        .data_o    (bus.rt_data_o)
    );

endmodule

// File: tb/tb_reg_file.sv
// Directed + short random bench for reg_file with a reference model of the
// register contents; expected read values are queued when the read is driven
// and popped when the outputs are sampled.
module tb_reg_file;

    logic clk;
    logic rst;

    reg_file_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    reg_file dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned errors = 0;
    int unsigned checks = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mdl[32];

`ifdef REG_FILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end

    function automatic void mdl_reset();
        for (int i = 0; i < 32; i++) mdl[i] = (i == 29) ? 32'd128 : 32'd0;
    endfunction

    function automatic void mdl_write(input logic we, input logic [4:0] a, input logic [31:0] d);
        if (we && a != 5'd0) mdl[a] = d;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s: scoreboard empty, observed %h", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", tag, obs, e);
            end
        end
    endtask

    // Drive both read addresses, queue the expectations, then sample.
    task automatic read_chk(input string tag, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [31:0] ers, input logic [31:0] ert);
        bus.rs_addr_i = rs;
        bus.rt_addr_i = rt;
        exp_q.push_back(ers);
        exp_q.push_back(ert);
        #1;
        check({tag, "_rs"}, bus.rs_data_o);
        check({tag, "_rt"}, bus.rt_data_o);
    endtask

    task automatic write(input logic [4:0] a, input logic [31:0] d);
        bus.reg_write_i = 1'b1;
        bus.rd_addr_i   = a;
        bus.rd_data_i   = d;
        tick();
        mdl_write(1'b1, a, d);
        bus.reg_write_i = 1'b0;
    endtask

    initial begin
        logic [4:0]  ra, rb;
        logic [31:0] rd;
        logic        we;

        rst             = 1'b1;
        bus.reg_write_i = 1'b0;
        bus.rs_addr_i   = '0;
        bus.rt_addr_i   = '0;
        bus.rd_addr_i   = '0;
        bus.rd_data_i   = '0;
        tick();
        rst = 1'b0;
        mdl_reset();

        // Reset sweep: rt walks the addresses in the opposite order.
        for (int a = 0; a < 32; a++) begin
            read_chk("reset_sweep", 5'(a), 5'(31 - a),
                     (a == 29) ? 32'd128 : 32'd0, (31 - a == 29) ? 32'd128 : 32'd0);
            tick();
        end

        // Basic write/read on both ports.
        write(5'd5, 32'hDEADBEEF);
        read_chk("basic_r5", 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF);

        // Writes to r0 are dropped.
        write(5'd0, 32'h12345678);
        read_chk("zero_reg", 5'd0, 5'd0, 32'd0, 32'd0);

        // Same-cycle read of the register being written.
        write(5'd7, 32'h11);
        bus.reg_write_i = 1'b1;
        bus.rd_addr_i   = 5'd7;
        bus.rd_data_i   = 32'h22;
        read_chk("hazard_pre", 5'd7, 5'd5, BYP ? 32'h22 : 32'h11, 32'hDEADBEEF);
        tick();
        mdl_write(1'b1, 5'd7, 32'h22);
        bus.reg_write_i = 1'b0;
        read_chk("hazard_post", 5'd7, 5'd7, 32'h22, 32'h22);

        // Bypass must never apply to r0.
        bus.reg_write_i = 1'b1;
        bus.rd_addr_i   = 5'd0;
        bus.rd_data_i   = 32'hAA;
        read_chk("zero_bypass", 5'd0, 5'd0, 32'd0, 32'd0);
        tick();
        bus.reg_write_i = 1'b0;

        // Write disabled.
        bus.rd_addr_i = 5'd3;
        bus.rd_data_i = 32'hFF;
        tick();
        read_chk("write_dis", 5'd3, 5'd3, 32'd0, 32'd0);

        // Reset wins over a same-edge write; earlier writes are lost.
        rst             = 1'b1;
        bus.reg_write_i = 1'b1;
        bus.rd_addr_i   = 5'd29;
        bus.rd_data_i   = 32'h55;
        tick();
        rst             = 1'b0;
        bus.reg_write_i = 1'b0;
        mdl_reset();
        read_chk("rst_prio", 5'd29, 5'd5, 32'd128, 32'd0);
        read_chk("rst_lost", 5'd7, 5'd29, 32'd0, 32'd128);

        // First write after reset is accepted.
        bus.reg_write_i = 1'b1;
        bus.rd_addr_i   = 5'd29;
        bus.rd_data_i   = 32'h55;
        read_chk("post_rst_pre", 5'd29, 5'd29, BYP ? 32'h55 : 32'd128, BYP ? 32'h55 : 32'd128);
        tick();
        mdl_write(1'b1, 5'd29, 32'h55);
        bus.reg_write_i = 1'b0;
        read_chk("post_rst_wr", 5'd29, 5'd0, 32'h55, 32'd0);

        // Short random write/read mix against the model.
        for (int n = 0; n < 40; n++) begin
            ra = 5'($urandom_range(0, 31));
            rb = 5'($urandom_range(0, 31));
            rd = $urandom;
            we = 1'($urandom_range(0, 1));
            bus.reg_write_i = we;
            bus.rd_addr_i   = ra;
            bus.rd_data_i   = rd;
            tick();
            mdl_write(we, ra, rd);
            bus.reg_write_i = 1'b0;
            read_chk("random", ra, rb, mdl[ra], mdl[rb]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
